// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, serialiser state encoding and parity helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  function automatic logic parity_bit(input logic [7:0] data, input int unsigned parity);
    return (parity == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word head output and occupancy count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign full  = (level_q == LvlW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: byte FIFO feeding an 8-bit LSB-first serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        uart_txo,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d, bit_next;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            txo_q, txo_d;
  logic            pop, full, empty, bit_done;
  logic [7:0]      head;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (pop),
    .head     (head),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

  assign bit_done = (cnt_q == CntLast);
  assign bit_next = bit_idx_q + 3'd1;

  // txo_d is the line level for the state being entered, so uart_txo stays a pure flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_d     = byte_q;
    txo_d      = txo_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          byte_d  = head;
          state_d = StStart;
          txo_d   = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
          txo_d     = byte_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              state_d = StParity;
              txo_d   = parity_bit(byte_q, PARITY);
            end else begin
              state_d    = StStop;
              stop_idx_d = 1'b0;
              txo_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_next;
            txo_d     = byte_q[bit_next];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          cnt_d      = '0;
          state_d    = StStop;
          stop_idx_d = 1'b0;
          txo_d      = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          cnt_d = '0;
          if (STOP_BITS == 2 && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (!empty) begin
            pop     = 1'b1;
            byte_d  = head;
            state_d = StStart;
            txo_d   = 1'b0;
          end else begin
            state_d = StIdle;
            txo_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txo_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      byte_q     <= 8'h00;
      txo_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      byte_q     <= byte_d;
      txo_q      <= txo_d;
    end
  end

  assign uart_txo = txo_q;
  assign in_ready = ~full;
  assign busy     = (state_q != StIdle) | (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parity/stop configurations share one input stream and are
// checked cycle by cycle against a frame-arithmetic line model.
module tb_uart_tx;

  localparam int C     = 4;
  localparam int N     = 3;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       txo [N];
  logic       rdy [N];
  logic       bsy [N];
  logic [4:0] lvl [N];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sent[$];
  int         acc_hist[$];
  int         push_at[$];
  logic [7:0] push_val[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .uart_txo(txo[0]), .busy(bsy[0]), .fifo_level(lvl[0])
  );
  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .uart_txo(txo[1]), .busy(bsy[1]), .fifo_level(lvl[1])
  );
  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .uart_txo(txo[2]), .busy(bsy[2]), .fifo_level(lvl[2])
  );

  function automatic int par_of(input int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // Clock cycles per complete frame.
  function automatic int frame_clks(input int d);
    return (9 + ((par_of(d) != 0) ? 1 : 0) + stop_of(d)) * C;
  endfunction

  // Line level for bit slot k of a frame carrying b.
  function automatic logic frame_bit(input int d, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par_of(d) != 0) begin
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return (par_of(d) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  // Expected occupancy after edge j: accepted bytes minus frames started so far.
  function automatic int exp_level(input int d, input int j);
    int a, p;
    if (j < 0) return 0;
    a = acc_hist[j];
    p = (j >= 1) ? ((j - 1) / frame_clks(d) + 1) : 0;
    if (p > a) p = a;
    return a - p;
  endfunction

  function automatic logic exp_txo(input int d, input int j);
    int u;
    if (j < 1) return 1'b1;
    u = j - 1;
    if (u >= acc_hist[j] * frame_clks(d)) return 1'b1;
    return frame_bit(d, sent[u / frame_clks(d)], (u % frame_clks(d)) / C);
  endfunction

  function automatic logic exp_busy(input int d, input int j);
    if (j < 0) return 1'b0;
    if (exp_level(d, j) > 0) return 1'b1;
    return (j >= 1) && (j - 1 < acc_hist[j] * frame_clks(d));
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h at %0t", tag, d, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < N; d++) begin
      check({tag, "_txo"}, d, 32'(txo[d]), 32'd1);
      check({tag, "_ready"}, d, 32'(rdy[d]), 32'd1);
      check({tag, "_busy"}, d, 32'(bsy[d]), 32'd0);
      check({tag, "_level"}, d, 32'(lvl[d]), 32'd0);
    end
  endtask

  // Entered at a negedge with all DUTs idle; iteration i sits just before edge i.
  task automatic run_stream(input string tag, input int ncyc);
    int acc = 0;
    sent.delete();
    acc_hist.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (i >= 1) begin
        for (int d = 0; d < N; d++) begin
          check({tag, "_txo"}, d, 32'(txo[d]), 32'(exp_txo(d, i - 1)));
          check({tag, "_level"}, d, 32'(lvl[d]), 32'(exp_level(d, i - 1)));
          check({tag, "_ready"}, d, 32'(rdy[d]), 32'(exp_level(d, i - 1) != DEPTH));
          check({tag, "_busy"}, d, 32'(bsy[d]), 32'(exp_busy(d, i - 1)));
        end
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (push_at.size() > 0 && push_at[0] == i) begin
        void'(push_at.pop_front());
        in_valid = 1'b1;
        in_data  = push_val.pop_front();
        if (exp_level(0, i - 1) < DEPTH) begin
          sent.push_back(in_data);
          acc++;
        end
      end
      acc_hist.push_back(acc);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int t;

    // Reset state, both during and after reset.
    repeat (2) @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_released");

    // Single 0x55 frame.
    push_at = '{0};
    push_val = '{8'h55};
    run_stream("byte55", 60);

    // Parity pattern 0x07: even parity 1, odd parity 0.
    push_at = '{0};
    push_val = '{8'h07};
    run_stream("byte07", 60);

    // 18 consecutive pushes: 17 accepted, back-to-back frames.
    for (int i = 0; i < 18; i++) begin
      push_at.push_back(i);
      push_val.push_back(8'($urandom));
    end
    run_stream("fill", 2 + 17 * 48 + 6);

    // Push exactly on dut0's pop cycle while one byte is queued.
    push_at = '{0, 37, 41};
    push_val = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_stream("pushpop", 2 + 3 * 48 + 6);

    // Random bytes arriving at random points, always before they are needed.
    push_at.push_back(0);
    push_val.push_back(8'($urandom));
    for (int k = 1; k < 5; k++) begin
      push_at.push_back(40 * (k - 1) + $urandom_range(1, 39));
      push_val.push_back(8'($urandom));
    end
    run_stream("random", 2 + 5 * 48 + 6);

    // Reset during dut0 data bit 3 (driven low) with one byte still queued.
    b = 8'($urandom) & 8'hF7;
    push_at = '{0, 1};
    push_val = '{b, 8'($urandom)};
    run_stream("prereset", 19);
    check("bit3_low", 0, 32'(txo[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    repeat (60) begin
      @(negedge clk);
      t++;
      if (t % 10 == 0) check_idle("post_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
